// File: rtl/idex_stage.sv
// -----------------------------------------------------------------------------
// idex_stage
//
// ID/EX pipeline register with integrated ALU-control decode. It sits between
// the decode/register-file stage and the EX/ALU stage. It adds a valid bit,
// stall and flush, and a MUL occupancy counter that back-pressures ID while a
// multi-cycle multiply owns EX.
//
// Update priority on each rising edge:
//   rst_i > flush_i > stall_i > MUL busy hold > load
//
// Optional feature (compile-time macro IDEX_ILLEGAL_TRAP_EN):
//   defined   : an illegal decode of a valid instruction sets illegal_o with the
//               instruction, forces its wb/mem to 0, and is never treated as MUL.
//   undefined : illegal_o is always 0; illegal keys decode as ADD and wb/mem
//               pass through unchanged.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   in_valid_i                 ID holds a real instruction
//   stall_i                    hold all state (including the MUL counter)
//   flush_i                    squash stage contents, wins over stall/busy
//   rs1_data_i, rs2_data_i     register operands            (XLEN)
//   iimm_i, simm_i             I/S immediates                (XLEN)
//   rs1_addr_i, rs2_addr_i,
//   rd_addr_i                  register addresses            (RA_W)
//   funct3_i, funct7_i         instruction function fields
//   alu_op_i                   00 add, 01 sub, 10 R-type, 11 I-type arith
//   alu_src_i                  1 selects iimm_i as val2
//   wb_i, mem_i                write enable, {mem_read, mem_write}
//   valid_o                    EX holds a completed, consumable instruction
//   val1_o, val2_o, simm_o     registered operands
//   alu_ctrl_o                 registered ALU control
//   rs1_addr_o, rs2_addr_o,
//   rd_addr_o                  registered addresses
//   wb_o, mem_o                registered controls, gated by valid_o
//   busy_o                     MUL in progress; ID must hold its instruction
//   illegal_o                  registered illegal-decode flag
// -----------------------------------------------------------------------------
module idex_stage #(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int MUL_CYCLES = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] iimm_i,
    input  logic [XLEN-1:0] simm_i,
    input  logic [RA_W-1:0] rs1_addr_i,
    input  logic [RA_W-1:0] rs2_addr_i,
    input  logic [RA_W-1:0] rd_addr_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [1:0]      alu_op_i,
    input  logic            alu_src_i,
    input  logic            wb_i,
    input  logic [1:0]      mem_i,
    output logic            valid_o,
    output logic [XLEN-1:0] val1_o,
    output logic [XLEN-1:0] val2_o,
    output logic [XLEN-1:0] simm_o,
    output logic [3:0]      alu_ctrl_o,
    output logic [RA_W-1:0] rs1_addr_o,
    output logic [RA_W-1:0] rs2_addr_o,
    output logic [RA_W-1:0] rd_addr_o,
    output logic            wb_o,
    output logic [1:0]      mem_o,
    output logic            busy_o,
    output logic            illegal_o
);

    // Counter only needs to hold MUL_CYCLES-1.
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // ALU-control decode (combinational, captured on load)
    // ------------------------------------------------------------------
    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_is_mul;

    always_comb begin
        dec_ctrl    = 4'b0010;
        dec_illegal = 1'b0;
        case (alu_op_i)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: dec_ctrl = 4'b0110;
            2'b10: begin
                case ({funct7_i, funct3_i})
                    10'b0000000_000: dec_ctrl = 4'b0010;
                    10'b0100000_000: dec_ctrl = 4'b0110;
                    10'b0000000_111: dec_ctrl = 4'b0000;
                    10'b0000000_110: dec_ctrl = 4'b0001;
                    10'b0000000_100: dec_ctrl = 4'b0011;
                    10'b0000000_001: dec_ctrl = 4'b0100;
                    10'b0000000_101: dec_ctrl = 4'b0101;
                    10'b0100000_101: dec_ctrl = 4'b0111;
                    10'b0000001_000: dec_ctrl = 4'b1111;
                    default: begin
                        dec_ctrl = 4'b0010;
`ifdef IDEX_ILLEGAL_TRAP_EN
                        dec_illegal = 1'b1;
`endif
                    end
                endcase
            end
            default: begin
                // I-type arithmetic: funct3 selects; funct7 only splits SRLI/SRAI.
                case (funct3_i)
                    3'b000: dec_ctrl = 4'b0010;
                    3'b111: dec_ctrl = 4'b0000;
                    3'b110: dec_ctrl = 4'b0001;
                    3'b100: dec_ctrl = 4'b0011;
                    3'b001: dec_ctrl = 4'b0100;
                    3'b101: dec_ctrl = (funct7_i == 7'b0100000) ? 4'b0111 : 4'b0101;
                    default: begin
                        dec_ctrl = 4'b0010;
`ifdef IDEX_ILLEGAL_TRAP_EN
                        dec_illegal = 1'b1;
`endif
                    end
                endcase
            end
        endcase
    end

    // Only the R-type MUL key produces 1111; an illegal key never does.
    assign dec_is_mul = (dec_ctrl == 4'b1111) && !dec_illegal;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic            valid_q,   valid_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic            busy_q,    busy_d;
    logic [XLEN-1:0] val1_q,    val1_d;
    logic [XLEN-1:0] val2_q,    val2_d;
    logic [XLEN-1:0] simm_q,    simm_d;
    logic [3:0]      ctrl_q,    ctrl_d;
    logic [RA_W-1:0] rs1_q,     rs1_d;
    logic [RA_W-1:0] rs2_q,     rs2_d;
    logic [RA_W-1:0] rd_q,      rd_d;
    logic            wb_q,      wb_d;
    logic [1:0]      mem_q,     mem_d;
    logic            illegal_q, illegal_d;

    logic trap_v;
    assign trap_v = in_valid_i && dec_illegal;

    always_comb begin
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        val1_d    = val1_q;
        val2_d    = val2_q;
        simm_d    = simm_q;
        ctrl_d    = ctrl_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        wb_d      = wb_q;
        mem_d     = mem_q;
        illegal_d = illegal_q;

        if (flush_i) begin
            // Squash wins over stall and over an in-flight MUL.
            valid_d   = 1'b0;
            cnt_d     = '0;
            val1_d    = '0;
            val2_d    = '0;
            simm_d    = '0;
            ctrl_d    = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            wb_d      = 1'b0;
            mem_d     = 2'b00;
            illegal_d = 1'b0;
        end else if (stall_i) begin
            // Everything holds, including the MUL counter.
        end else if (cnt_q != '0) begin
            // MUL still occupies EX: count down and keep the contents.
            // No load on the cycle cnt goes 1 -> 0; ID loads one cycle later.
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            valid_d   = in_valid_i;
            cnt_d     = (in_valid_i && dec_is_mul) ? CNT_LOAD : '0;
            val1_d    = rs1_data_i;
            val2_d    = alu_src_i ? iimm_i : rs2_data_i;
            simm_d    = simm_i;
            ctrl_d    = dec_ctrl;
            rs1_d     = rs1_addr_i;
            rs2_d     = rs2_addr_i;
            rd_d      = rd_addr_i;
            wb_d      = wb_i && !trap_v;
            mem_d     = trap_v ? 2'b00 : mem_i;
            illegal_d = trap_v;
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            val1_q    <= '0;
            val2_q    <= '0;
            simm_q    <= '0;
            ctrl_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wb_q      <= 1'b0;
            mem_q     <= 2'b00;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            val1_q    <= val1_d;
            val2_q    <= val2_d;
            simm_q    <= simm_d;
            ctrl_q    <= ctrl_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            wb_q      <= wb_d;
            mem_q     <= mem_d;
            illegal_q <= illegal_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign valid_o    = valid_q && (cnt_q == '0);
    assign busy_o     = busy_q;
    assign val1_o     = val1_q;
    assign val2_o     = val2_q;
    assign simm_o     = simm_q;
    assign alu_ctrl_o = ctrl_q;
    assign rs1_addr_o = rs1_q;
    assign rs2_addr_o = rs2_q;
    assign rd_addr_o  = rd_q;
    assign wb_o       = wb_q && valid_o;
    assign mem_o      = mem_q & {2{valid_o}};
    assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_idex_stage.sv
module tb_idex_stage;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

`ifdef IDEX_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic            in_valid_i, stall_i, flush_i;
    logic [XLEN-1:0] rs1_data_i, rs2_data_i, iimm_i, simm_i;
    logic [RA_W-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [2:0]      funct3_i;
    logic [6:0]      funct7_i;
    logic [1:0]      alu_op_i;
    logic            alu_src_i, wb_i;
    logic [1:0]      mem_i;
    logic            valid_o;
    logic [XLEN-1:0] val1_o, val2_o, simm_o;
    logic [3:0]      alu_ctrl_o;
    logic [RA_W-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic            wb_o;
    logic [1:0]      mem_o;
    logic            busy_o, illegal_o;

    idex_stage #(.XLEN(XLEN), .RA_W(RA_W), .MUL_CYCLES(3)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .stall_i(stall_i),
        .flush_i(flush_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .iimm_i(iimm_i), .simm_i(simm_i), .rs1_addr_i(rs1_addr_i),
        .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .alu_op_i(alu_op_i), .alu_src_i(alu_src_i),
        .wb_i(wb_i), .mem_i(mem_i), .valid_o(valid_o), .val1_o(val1_o),
        .val2_o(val2_o), .simm_o(simm_o), .alu_ctrl_o(alu_ctrl_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .wb_o(wb_o), .mem_o(mem_o), .busy_o(busy_o), .illegal_o(illegal_o)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic            ill;
        logic [3:0]      ctrl;
        logic            wb;
        logic [1:0]      mem;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;
        logic [XLEN-1:0] si;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle EX presents valid_o, one expected instruction retires.
    always @(negedge clk) begin
        exp_t a, e;
        if (!rst_i && valid_o) begin
            a = '{illegal_o, alu_ctrl_o, wb_o, mem_o, rd_addr_o, rs1_addr_o,
                  rs2_addr_o, val1_o, val2_o, simm_o};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid actual ctrl=%b rd=%0d v1=%h required none t=%0t",
                         a.ctrl, a.rd, a.v1, $time);
            end else begin
                e = exp_t'(exp_q.pop_front());
                if (a !== e) begin
                    failures++;
                    $display("FAIL retire actual ill=%b ctrl=%b wb=%b mem=%b rd=%0d rs1=%0d rs2=%0d v1=%h v2=%h si=%h required ill=%b ctrl=%b wb=%b mem=%b rd=%0d rs1=%0d rs2=%0d v1=%h v2=%h si=%h t=%0t",
                             a.ill, a.ctrl, a.wb, a.mem, a.rd, a.rs1, a.rs2, a.v1, a.v2, a.si,
                             e.ill, e.ctrl, e.wb, e.mem, e.rd, e.rs1, e.rs2, e.v1, e.v2, e.si, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid_i = 1'b0;
        wb_i       = 1'b0;
        mem_i      = 2'b00;
    endtask

    task automatic put(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic src, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rd,
                       input logic wbv, input logic [1:0] memv);
        in_valid_i = 1'b1;
        alu_op_i   = op;
        funct7_i   = f7;
        funct3_i   = f3;
        alu_src_i  = src;
        rs1_data_i = a;
        rs2_data_i = b;
        iimm_i     = imm;
        simm_i     = ~imm;
        rd_addr_i  = rd;
        rs1_addr_i = rd + 5'd1;
        rs2_addr_i = rd + 5'd2;
        wb_i       = wbv;
        mem_i      = memv;
    endtask

    // Expected retirement of the instruction currently driven, with its
    // hand-decoded ALU control and illegal flag.
    task automatic push(input logic [3:0] ctrl, input logic ill);
        exp_t e;
        e.ill  = ill;
        e.ctrl = ctrl;
        e.wb   = ill ? 1'b0 : wb_i;
        e.mem  = ill ? 2'b00 : mem_i;
        e.rd   = rd_addr_i;
        e.rs1  = rs1_addr_i;
        e.rs2  = rs2_addr_i;
        e.v1   = rs1_data_i;
        e.v2   = alu_src_i ? iimm_i : rs2_data_i;
        e.si   = simm_i;
        exp_q.push_back(W'(e));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        in_valid_i = 1'b0; rs1_data_i = '0; rs2_data_i = '0; iimm_i = '0; simm_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0; funct3_i = '0; funct7_i = '0;
        alu_op_i = '0; alu_src_i = 1'b0; wb_i = 1'b0; mem_i = '0;
        repeat (2) tick();
        check("rst_valid", 32'(valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_wb_mem_ill", {29'd0, wb_o, mem_o}, 0);
        check("rst_illegal", 32'(illegal_o), 0);
        check("rst_ctrl", 32'(alu_ctrl_o), 0);
        check("rst_val1", val1_o, 0);
        rst_i = 1'b0;

        // Directed decode vectors, back to back.
        put(2'b10, 7'h00, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 2'b00); push(4'b0010, 1'b0); tick(); // ADD
        put(2'b11, 7'h00, 3'd0, 1'b1, 32'h10, 32'd9, 32'hFFFF_FFFC, 5'd4, 1'b1, 2'b00); push(4'b0010, 1'b0); tick(); // ADDI
        put(2'b11, 7'h20, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0403, 5'd5, 1'b1, 2'b00); push(4'b0111, 1'b0); tick(); // SRAI
        put(2'b10, 7'h20, 3'd0, 1'b0, 32'd20, 32'd3, 32'd0, 5'd6, 1'b1, 2'b00); push(4'b0110, 1'b0); tick(); // SUB
        put(2'b10, 7'h00, 3'd7, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 5'd7, 1'b1, 2'b00); push(4'b0000, 1'b0); tick(); // AND
        put(2'b10, 7'h00, 3'd6, 1'b0, 32'h1, 32'h2, 32'd0, 5'd8, 1'b1, 2'b00); push(4'b0001, 1'b0); tick(); // OR
        put(2'b10, 7'h00, 3'd4, 1'b0, 32'hAA, 32'h55, 32'd0, 5'd9, 1'b1, 2'b00); push(4'b0011, 1'b0); tick(); // XOR
        put(2'b10, 7'h00, 3'd1, 1'b0, 32'h3, 32'h4, 32'd0, 5'd10, 1'b1, 2'b00); push(4'b0100, 1'b0); tick(); // SLL
        put(2'b10, 7'h00, 3'd5, 1'b0, 32'h80, 32'h2, 32'd0, 5'd11, 1'b1, 2'b00); push(4'b0101, 1'b0); tick(); // SRL
        put(2'b10, 7'h20, 3'd5, 1'b0, 32'h8000_0080, 32'h2, 32'd0, 5'd12, 1'b1, 2'b00); push(4'b0111, 1'b0); tick(); // SRA
        put(2'b00, 7'h7F, 3'd2, 1'b1, 32'h1000, 32'h0, 32'h0000_0008, 5'd13, 1'b1, 2'b10); push(4'b0010, 1'b0); tick(); // LW
        put(2'b01, 7'h00, 3'd0, 1'b0, 32'd9, 32'd9, 32'd0, 5'd0, 1'b0, 2'b00); push(4'b0110, 1'b0); tick(); // BEQ
        put(2'b11, 7'h00, 3'd7, 1'b1, 32'h77, 32'h0, 32'h0000_000F, 5'd14, 1'b1, 2'b00); push(4'b0000, 1'b0); tick(); // ANDI
        put(2'b11, 7'h00, 3'd6, 1'b1, 32'h77, 32'h0, 32'h0000_0100, 5'd15, 1'b1, 2'b00); push(4'b0001, 1'b0); tick(); // ORI
        put(2'b11, 7'h00, 3'd4, 1'b1, 32'h77, 32'h0, 32'hFFFF_FFFF, 5'd16, 1'b1, 2'b00); push(4'b0011, 1'b0); tick(); // XORI
        put(2'b11, 7'h00, 3'd1, 1'b1, 32'h1, 32'h0, 32'h0000_0004, 5'd17, 1'b1, 2'b00); push(4'b0100, 1'b0); tick(); // SLLI
        put(2'b11, 7'h00, 3'd5, 1'b1, 32'h100, 32'h0, 32'h0000_0004, 5'd18, 1'b1, 2'b00); push(4'b0101, 1'b0); tick(); // SRLI
        idle(); tick();
        tick();
        check("bubble_valid", 32'(valid_o), 0);

        // MUL followed immediately by an ADD held by ID while busy.
        put(2'b10, 7'h01, 3'd0, 1'b0, 32'd6, 32'd7, 32'd0, 5'd19, 1'b1, 2'b00); push(4'b1111, 1'b0); tick();
        check("mul_busy_c1", 32'(busy_o), 1);
        check("mul_valid_c1", 32'(valid_o), 0);
        check("mul_wb_gated", 32'(wb_o), 0);
        put(2'b10, 7'h00, 3'd0, 1'b0, 32'd11, 32'd12, 32'd0, 5'd20, 1'b1, 2'b00); push(4'b0010, 1'b0); tick();
        check("mul_busy_c2", 32'(busy_o), 1);
        check("mul_valid_c2", 32'(valid_o), 0);
        tick();
        check("mul_busy_drop", 32'(busy_o), 0);
        check("mul_valid_c3", 32'(valid_o), 1);
        tick();
        idle(); tick();

        // MUL with a three-cycle stall while busy.
        put(2'b10, 7'h01, 3'd0, 1'b0, 32'd3, 32'd4, 32'd0, 5'd21, 1'b1, 2'b00); push(4'b1111, 1'b0); tick();
        check("stl_busy_c1", 32'(busy_o), 1);
        idle(); stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_busy_held", 32'(busy_o), 1);
            check("stl_valid_held", 32'(valid_o), 0);
            check("stl_ctrl_held", 32'(alu_ctrl_o), 32'hF);
            check("stl_val1_held", val1_o, 32'd3);
        end
        stall_i = 1'b0; tick();
        check("stl_busy_c5", 32'(busy_o), 1);
        tick();
        check("stl_busy_drop", 32'(busy_o), 0);
        check("stl_valid_out", 32'(valid_o), 1);
        tick();

        // Flush together with stall of a loaded SW.
        put(2'b00, 7'h00, 3'd2, 1'b0, 32'h200, 32'hABCD, 32'h0000_0010, 5'd0, 1'b0, 2'b01); push(4'b0010, 1'b0); tick();
        idle(); stall_i = 1'b1; flush_i = 1'b1; tick();
        check("fl_valid", 32'(valid_o), 0);
        check("fl_mem", 32'(mem_o), 0);
        check("fl_wb", 32'(wb_o), 0);
        check("fl_busy", 32'(busy_o), 0);
        check("fl_val1", val1_o, 0);
        stall_i = 1'b0; flush_i = 1'b0; tick();

        // Flush of an in-flight MUL.
        put(2'b10, 7'h01, 3'd0, 1'b0, 32'd8, 32'd9, 32'd0, 5'd22, 1'b1, 2'b00); tick();
        check("flm_busy_before", 32'(busy_o), 1);
        idle(); flush_i = 1'b1; tick();
        check("flm_busy_after", 32'(busy_o), 0);
        check("flm_valid_after", 32'(valid_o), 0);
        flush_i = 1'b0; tick();

        // Illegal keys: R-type 0000000_010, I-type funct3 011, MUL-like 0000001_001.
        put(2'b10, 7'h00, 3'd2, 1'b0, 32'd1, 32'd2, 32'd0, 5'd23, 1'b1, 2'b00); push(4'b0010, TRAP); tick();
        check("ill_rtype_flag", 32'(illegal_o), 32'(TRAP));
        check("ill_rtype_wb", 32'(wb_o), 32'(!TRAP));
        put(2'b11, 7'h00, 3'd3, 1'b1, 32'd1, 32'd0, 32'd5, 5'd24, 1'b1, 2'b10); push(4'b0010, TRAP); tick();
        put(2'b10, 7'h01, 3'd1, 1'b0, 32'd4, 32'd5, 32'd0, 5'd25, 1'b1, 2'b00); push(4'b0010, TRAP); tick();
        check("ill_not_mul_busy", 32'(busy_o), 0);
        idle(); tick();

        // Reset wins over a pending load.
        put(2'b10, 7'h00, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd26, 1'b1, 2'b00);
        rst_i = 1'b1; tick();
        check("rst_over_load", 32'(valid_o), 0);
        rst_i = 1'b0; idle();

        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- Parametrised ID/EX pipeline register with integrated ALU-control decode.
- Adds the following to the current ID/EX boundary:
  - valid bit
  - synchronous reset
  - stall and flush
  - wider decode (XOR/SLL/SRL/SRA, I-type)
  - multi-cycle MUL occupancy counter that back-pressures ID.
- Sits between the decode/register-file stage and the EX/ALU stage.

Parameters:
XLEN, 32, datapath width of operands and immediates
RA_W, 5, register address width
MUL_CYCLES, 3, cycles a MUL occupies EX (1 = single-cycle, no busy)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
in_valid_i  in  1  ID holds a real instruction
stall_i  in  1  downstream/hazard stall; hold all state
flush_i  in  1  squash stage contents (branch/redirect)
rs1_data_i, rs2_data_i, iimm_i, simm_i  in  XLEN  operands and I/S immediates
rs1_addr_i, rs2_addr_i, rd_addr_i  in  RA_W  register addresses
funct3_i  in  3  instruction funct3
funct7_i  in  7  instruction funct7
alu_op_i  in  2  00 add, 01 sub, 10 R-type, 11 I-type arith
alu_src_i  in  1  1 selects iimm_i for val2
wb_i  in  1  register write enable
mem_i  in  2  {mem_read, mem_write}
valid_o  out  1  EX holds a completed, consumable instruction
val1_o, val2_o, simm_o  out  XLEN  registered operands
alu_ctrl_o  out  4  registered ALU control
rs1_addr_o, rs2_addr_o, rd_addr_o  out  RA_W  registered addresses
wb_o  out  1  registered wb, gated by valid_o
mem_o  out  2  registered mem, gated by valid_o
busy_o  out  1  MUL in progress; ID must hold
illegal_o  out  1  registered illegal-decode flag (see Optional Feature)

Behaviour:
- Priority each edge: rst_i > flush_i > stall_i > busy hold > load.
- Reset:
  - All registered outputs 0.
  - Internal valid 0.
  - MUL counter cnt 0.
  - valid_o, busy_o, wb_o, mem_o, illegal_o all 0.
- Load (no rst/flush/stall, cnt==0):
  - Capture all inputs.
  - val2 = alu_src_i ? iimm_i : rs2_data_i.
  - Internal valid = in_valid_i.
  - Latency 1 cycle.
- Decode (combinational, registered on load):
  - alu_op 00 → 0010; alu_op 01 → 0110.
  - alu_op 10, key {funct7,funct3}:
    - 0000000_000 → 0010 ADD
    - 0100000_000 → 0110 SUB
    - 0000000_111 → 0000 AND
    - 0000000_110 → 0001 OR
    - 0000000_100 → 0011 XOR
    - 0000000_001 → 0100 SLL
    - 0000000_101 → 0101 SRL
    - 0100000_101 → 0111 SRA
    - 0000001_000 → 1111 MUL
  - alu_op 11, key funct3 only:
    - 000 → 0010; 111 → 0000; 110 → 0001; 100 → 0011; 001 → 0100
    - 101 → 0101, or 0111 if funct7 = 0100000.
  - Any other key is illegal; alu_ctrl = 0010.
- MUL occupancy:
  - On load of a valid MUL with MUL_CYCLES>1, cnt ← MUL_CYCLES-1.
  - While cnt!=0 and !stall_i: cnt decrements by 1, and stage contents are held.
  - busy_o = (cnt != 0), driven from a register; not combinational from inputs.
  - valid_o = internal valid & (cnt == 0). wb_o and mem_o are ANDed with valid_o.
  - With MUL_CYCLES=1, cnt stays 0.
- Stall: all registers and cnt hold; stall_i has no effect on busy_o's current value.
- Flush:
  - Internal valid 0, wb/mem/illegal 0, cnt 0, data registers 0.
  - Applies even while stalled or busy.
- Simultaneous events:
  - flush_i with stall_i → flush.
  - rst_i with anything → reset.
  - Load while cnt==1 and !stall_i → not permitted that cycle (busy_o still 1); load occurs the next cycle.

Optional Feature:
Macro IDEX_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal decode of a valid instruction sets illegal_o=1 with the instruction.
  - Forces registered wb and mem to 0 (no architectural side effect).
  - The instruction is never treated as MUL.
- Undefined:
  - illegal_o is tied 0.
  - Illegal keys decode as ADD (0010) with wb/mem passed through unchanged.

Test Plan:
- Reset then ADD (alu_op=10, funct=0000000_000, rs1=5, rs2=7, rd=3, wb=1) → next cycle valid_o=1, alu_ctrl_o=0010, val1_o=5, val2_o=7, rd_addr_o=3, wb_o=1.
- ADDI with alu_src=1, iimm=0xFFFFFFFC, alu_op=11, funct3=000 → val2_o=0xFFFFFFFC, alu_ctrl_o=0010; then SRAI (funct7=0100000, funct3=101) → 0111.
- MUL (0000001_000), MUL_CYCLES=3 → busy_o=1 and valid_o=0 for 2 cycles, then valid_o=1 with alu_ctrl_o=1111; following instruction loads only after busy_o drops.
- stall_i high 3 cycles during MUL busy → cnt frozen, busy_o stays 1 for 2+3 cycles total; outputs unchanged during stall.
- flush_i with a valid SW (mem=01) loaded, stall_i=1 simultaneously → next cycle valid_o=0, mem_o=00, wb_o=0, busy_o=0.
- IDEX_ILLEGAL_TRAP_EN defined, R-type funct 0000000_010 with wb=1 → illegal_o=1, wb_o=0, alu_ctrl_o=0010; undefined → illegal_o=0, wb_o=1.
